// File: rtl/matmul_pkg.sv
// -----------------------------------------------------------------------------
// matmul_pkg
// Shared definitions for the matmul memory subsystem:
//   clog2      - ceiling log2 helper, never below 1 so it can size index fields
//   IDXW/TAGW  - default engine-index and tag-FIFO pointer widths
//   *_DEF      - default memory geometry shared by engines and the arbiter
// -----------------------------------------------------------------------------
package matmul_pkg;

  // Ceiling log2; returns at least 1 so a result can always size a vector.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

  localparam int NREQ_DEF   = 2;
  localparam int MEM_AW_DEF = 16;
  localparam int MEM_DW_DEF = 32;
  localparam int OUTST_DEF  = 4;
  localparam int IDXW       = clog2(NREQ_DEF);
  localparam int TAGW       = clog2(OUTST_DEF);

endpackage

// File: rtl/mem_arb_tag_fifo.sv
// -----------------------------------------------------------------------------
// mem_arb_tag_fifo
// Synchronous FIFO of owner tags for outstanding reads. DEPTH must be a power
// of two so the pointers wrap naturally.
// Ports:
//   clk, rst   clock, asynchronous active-high reset (flushes the FIFO)
//   push, din  enqueue din; ignored when full unless a pop happens same cycle
//   pop        dequeue head; ignored when empty
//   full/empty occupancy flags
//   head       oldest entry (valid only when empty=0)
// -----------------------------------------------------------------------------
module mem_arb_tag_fifo
  import matmul_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PW = clog2(DEPTH);

  logic [WIDTH-1:0] store_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [PW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full  = (count_r == (PW + 1)'(DEPTH));
  assign empty = (count_r == {(PW + 1){1'b0}});
  assign head  = store_r[rd_ptr_r];

  // Qualify push/pop: a full FIFO still takes a push when it pops in the same cycle.
  always_comb begin
    do_pop_s  = pop & ~empty;
    do_push_s = push & (~full | do_pop_s);
  end

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {(PW + 1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        store_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      if (do_push_s) begin
        store_r[wr_ptr_r] <= din;
        wr_ptr_r          <= wr_ptr_r + {{(PW - 1){1'b0}}, 1'b1};
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(PW - 1){1'b0}}, 1'b1};
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + {{PW{1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{PW{1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port memory between NREQ engines. The current owner keeps
// the port while it keeps requesting; otherwise the next requester at or after
// the round-robin pointer wins in the same cycle. Losers (and a reading owner
// when the tag FIFO is full) are stalled through rq_ena. Read returns are
// steered to the issuing engine by an in-order owner-tag FIFO.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   rq_req/write/addr/wdata  packed per-engine command inputs
//   rq_ena                per-engine enable, 0 = stall this cycle
//   rq_rdata_vld/rq_rdata one-hot read-return strobe, broadcast read data
//   mem_*                 memory command (zero when mem_req=0) and read return
//   err_rd_unexp          sticky: read return seen with no read outstanding
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import matmul_pkg::*;
#(
  parameter int NREQ   = NREQ_DEF,
  parameter int MEM_AW = MEM_AW_DEF,
  parameter int MEM_DW = MEM_DW_DEF,
  parameter int OUTST  = OUTST_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        rq_req,
  input  logic [NREQ-1:0]        rq_write,
  input  logic [NREQ*MEM_AW-1:0] rq_addr,
  input  logic [NREQ*MEM_DW-1:0] rq_wdata,
  output logic [NREQ-1:0]        rq_ena,
  output logic [NREQ-1:0]        rq_rdata_vld,
  output logic [MEM_DW-1:0]      rq_rdata,
  output logic                   mem_req,
  output logic                   mem_write,
  output logic [MEM_AW-1:0]      mem_addr,
  output logic [MEM_DW-1:0]      mem_wdata,
  input  logic                   mem_rdata_vld,
  input  logic [MEM_DW-1:0]      mem_rdata,
  output logic                   err_rd_unexp
);

  localparam int IW = clog2(NREQ);

  logic [IW-1:0]     owner_r;
  logic              owner_vld_r;
  logic [IW-1:0]     rr_ptr_r;
  logic              err_rd_unexp_r;

  logic [IW-1:0]     win_s;
  logic              found_s;
  int                idx_s;
  logic              lock_s;
  logic              gnt_any_s;
  logic [IW-1:0]     gnt_idx_s;
  logic [NREQ-1:0]   gnt_s;
  logic              sel_write_s;
  logic              fifo_block_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [IW-1:0]     fifo_head_s;
  logic              push_s;
  logic              pop_s;
  logic              mem_req_s;
  logic              mem_write_s;
  logic [MEM_AW-1:0] mem_addr_s;
  logic [MEM_DW-1:0] mem_wdata_s;
  logic [NREQ-1:0]   rq_ena_s;
  logic [NREQ-1:0]   rq_rdata_vld_s;

  // Round-robin search: first requester at or above rr_ptr, wrapping.
  always_comb begin
    win_s   = rr_ptr_r;
    found_s = 1'b0;
    idx_s   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx_s = (int'(rr_ptr_r) + k) % NREQ;
      if (!found_s && rq_req[idx_s]) begin
        found_s = 1'b1;
        win_s   = IW'(idx_s);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Grant: a still-requesting owner holds the port, otherwise the RR winner takes it now.
  always_comb begin
    lock_s       = owner_vld_r & rq_req[owner_r];
    gnt_any_s    = |rq_req;
    gnt_idx_s    = lock_s ? owner_r : win_s;
    gnt_s        = gnt_any_s ? ({{(NREQ - 1){1'b0}}, 1'b1} << gnt_idx_s) : {NREQ{1'b0}};
    sel_write_s  = rq_write[gnt_idx_s];
    // A return popping this cycle frees the slot the new read needs.
    fifo_block_s = fifo_full_s & ~mem_rdata_vld;
  end

  // Stall vector and memory command mux; everything idles while reset is held.
  always_comb begin
    rq_ena_s    = {NREQ{1'b1}};
    mem_req_s   = 1'b0;
    mem_write_s = 1'b0;
    mem_addr_s  = {MEM_AW{1'b0}};
    mem_wdata_s = {MEM_DW{1'b0}};
    if (!rst) begin
      for (int i = 0; i < NREQ; i++) begin
        rq_ena_s[i] = ~(rq_req[i] & ~gnt_s[i]) & ~(gnt_s[i] & ~rq_write[i] & fifo_block_s);
      end
      mem_req_s = gnt_any_s & ~(~sel_write_s & fifo_block_s);
      if (mem_req_s) begin
        mem_write_s = sel_write_s;
        mem_addr_s  = rq_addr[int'(gnt_idx_s) * MEM_AW +: MEM_AW];
        mem_wdata_s = rq_wdata[int'(gnt_idx_s) * MEM_DW +: MEM_DW];
      end else begin
        mem_write_s = 1'b0;
      end
    end else begin
      rq_ena_s = {NREQ{1'b1}};
    end
  end

  // Tag FIFO traffic and return steering; an empty FIFO means the return is unexpected.
  always_comb begin
    push_s         = mem_req_s & ~mem_write_s;
    pop_s          = mem_rdata_vld & ~fifo_empty_s;
    rq_rdata_vld_s = {NREQ{1'b0}};
    if (pop_s) begin
      rq_rdata_vld_s = {{(NREQ - 1){1'b0}}, 1'b1} << fifo_head_s;
    end else begin
      rq_rdata_vld_s = {NREQ{1'b0}};
    end
  end

  mem_arb_tag_fifo #(
    .DEPTH (OUTST),
    .WIDTH (IW)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .din   (gnt_idx_s),
    .pop   (pop_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .head  (fifo_head_s)
  );

  // Owner, round-robin pointer and sticky unexpected-return flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_r        <= {IW{1'b0}};
      owner_vld_r    <= 1'b0;
      rr_ptr_r       <= {IW{1'b0}};
      err_rd_unexp_r <= 1'b0;
    end else begin
      owner_vld_r <= gnt_any_s;
      owner_r     <= gnt_any_s ? gnt_idx_s : owner_r;
      if (gnt_any_s && !lock_s) begin
        rr_ptr_r <= IW'((int'(win_s) + 1) % NREQ);
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end
      if (mem_rdata_vld && fifo_empty_s) begin
        err_rd_unexp_r <= 1'b1;
      end else begin
        err_rd_unexp_r <= err_rd_unexp_r;
      end
    end
  end

  assign rq_ena       = rq_ena_s;
  assign rq_rdata_vld = rq_rdata_vld_s;
  assign rq_rdata     = mem_rdata;
  assign mem_req      = mem_req_s;
  assign mem_write    = mem_write_s;
  assign mem_addr     = mem_addr_s;
  assign mem_wdata    = mem_wdata_s;
  assign err_rd_unexp = err_rd_unexp_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Random and directed traffic from two engines against a behavioural model of
// the arbitration rules plus a latency-configurable in-order memory model.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int NREQ  = 2;
  localparam int AW    = 16;
  localparam int DW    = 32;
  localparam int OUTST = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    rq_req;
  logic [NREQ-1:0]    rq_write;
  logic [NREQ*AW-1:0] rq_addr;
  logic [NREQ*DW-1:0] rq_wdata;
  logic [NREQ-1:0]    rq_ena;
  logic [NREQ-1:0]    rq_rdata_vld;
  logic [DW-1:0]      rq_rdata;
  logic               mem_req;
  logic               mem_write;
  logic [AW-1:0]      mem_addr;
  logic [DW-1:0]      mem_wdata;
  logic               mem_rdata_vld;
  logic [DW-1:0]      mem_rdata;
  logic               err_rd_unexp;

  mem_port_arbiter #(.NREQ(NREQ), .MEM_AW(AW), .MEM_DW(DW), .OUTST(OUTST)) dut (
    .clk           (clk),
    .rst           (rst),
    .rq_req        (rq_req),
    .rq_write      (rq_write),
    .rq_addr       (rq_addr),
    .rq_wdata      (rq_wdata),
    .rq_ena        (rq_ena),
    .rq_rdata_vld  (rq_rdata_vld),
    .rq_rdata      (rq_rdata),
    .mem_req       (mem_req),
    .mem_write     (mem_write),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata_vld (mem_rdata_vld),
    .mem_rdata     (mem_rdata),
    .err_rd_unexp  (err_rd_unexp)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int lat   = 3;

  // reference state
  int            m_own = 0;
  bit            m_ov  = 1'b0;
  int            m_rr  = 0;
  bit            m_err = 1'b0;
  int            m_q[$];
  logic [DW-1:0] m_qd[$];

  // memory model
  logic [DW-1:0] memarr [256];
  int            due_q[$];
  logic [DW-1:0] dat_q[$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic set_eng(input int e, input bit req, input bit wr, input logic [AW-1:0] a);
    rq_req[e]             = req;
    rq_write[e]           = wr;
    rq_addr[e*AW +: AW]   = a;
    rq_wdata[e*DW +: DW]  = $urandom();
  endtask

  // One clock: drive memory return, check outputs at negedge, advance models at posedge.
  task automatic step();
    bit            vld_now, any, lock, blk, found, emreq, ewr;
    int            g, idx;
    logic [1:0]    eena, ervld;
    logic [AW-1:0] ea;
    logic [DW-1:0] ewd;
    vld_now       = (due_q.size() > 0) && (due_q[0] <= cyc);
    mem_rdata_vld = vld_now;
    mem_rdata     = vld_now ? dat_q[0] : $urandom();
    @(negedge clk);
    any   = (rq_req != 2'b00);
    lock  = m_ov && rq_req[m_own];
    g     = m_rr;
    found = 1'b0;
    if (lock) g = m_own;
    else begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_rr + k) % NREQ;
        if (!found && rq_req[idx]) begin found = 1'b1; g = idx; end
      end
    end
    blk = (m_q.size() == OUTST) && !vld_now;
    for (int i = 0; i < NREQ; i++) begin
      eena[i] = !(rq_req[i] && !(any && g == i)) && !(any && g == i && !rq_write[i] && blk);
    end
    emreq = any && !(!rq_write[g] && blk);
    ewr   = emreq && rq_write[g];
    ea    = emreq ? rq_addr[g*AW +: AW] : 16'h0;
    ewd   = emreq ? rq_wdata[g*DW +: DW] : 32'h0;
    ervld = (vld_now && m_q.size() > 0) ? (2'b01 << m_q[0]) : 2'b00;
    if (rst) begin
      eena = 2'b11; emreq = 1'b0; ewr = 1'b0; ea = 16'h0; ewd = 32'h0; ervld = 2'b00;
    end
    check_val("rq_ena", 64'(rq_ena), 64'(eena));
    check_val("mem_req", 64'(mem_req), 64'(emreq));
    check_val("mem_write", 64'(mem_write), 64'(ewr));
    check_val("mem_addr", 64'(mem_addr), 64'(ea));
    check_val("mem_wdata", 64'(mem_wdata), 64'(ewd));
    check_val("rq_rdata_vld", 64'(rq_rdata_vld), 64'(ervld));
    check_val("err_rd_unexp", 64'(err_rd_unexp), 64'(rst ? 1'b0 : m_err));
    if (ervld != 2'b00) check_val("rq_rdata", 64'(rq_rdata), 64'(m_qd[0]));
    @(posedge clk);
    // arbiter reference
    if (rst) begin
      m_own = 0; m_ov = 1'b0; m_rr = 0; m_err = 1'b0;
      m_q.delete(); m_qd.delete();
    end else begin
      if (vld_now) begin
        if (m_q.size() > 0) begin
          void'(m_q.pop_front());
          void'(m_qd.pop_front());
        end else m_err = 1'b1;
      end
      if (emreq && !ewr) begin
        m_q.push_back(g);
        m_qd.push_back(memarr[ea[7:0]]);
      end
      if (any && !lock) m_rr = (g + 1) % NREQ;
      m_ov = any;
      if (any) m_own = g;
    end
    // memory reference keeps returning regardless of arbiter reset
    if (vld_now) begin
      void'(due_q.pop_front());
      void'(dat_q.pop_front());
    end
    if (emreq && ewr) memarr[ea[7:0]] = ewd;
    if (emreq && !ewr) begin
      due_q.push_back(cyc + lat);
      dat_q.push_back(memarr[ea[7:0]]);
    end
    cyc++;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) memarr[i] = 32'(i * 3 + 1);
    rst = 1'b1; rq_req = 2'b00; rq_write = 2'b00; rq_addr = '0; rq_wdata = '0;
    mem_rdata_vld = 1'b0; mem_rdata = '0;
    step();
    step();
    rst = 1'b0;
    step();

    // both request reads from reset; engine0 first, then engine1 once engine0 drops
    lat = 3;
    for (int t = 0; t < 6; t++) begin
      set_eng(0, 1'b1, 1'b0, 16'(t));
      set_eng(1, 1'b1, 1'b0, 16'(t + 64));
      step();
    end
    set_eng(0, 1'b0, 1'b0, 16'h0);
    for (int t = 0; t < 10; t++) step();
    set_eng(1, 1'b0, 1'b0, 16'h0);
    for (int t = 0; t < 10; t++) step();

    // interleaved single reads e0@0x10, e1@0x20
    set_eng(0, 1'b1, 1'b0, 16'h0010);
    step();
    set_eng(0, 1'b0, 1'b0, 16'h0);
    set_eng(1, 1'b1, 1'b0, 16'h0020);
    step();
    set_eng(1, 1'b0, 1'b0, 16'h0);
    for (int t = 0; t < 6; t++) step();

    // long latency stream: FIFO fills, engine0 stalls until returns arrive
    lat = 8;
    for (int t = 0; t < 24; t++) begin
      set_eng(0, 1'b1, 1'b0, 16'(t + 100));
      step();
    end
    set_eng(0, 1'b0, 1'b0, 16'h0);
    for (int t = 0; t < 12; t++) step();

    // both requesting with periodic drops, mixed reads/writes
    lat = 2;
    for (int t = 0; t < 40; t++) begin
      set_eng(0, (t % 5) != 4, t[0], 16'($urandom_range(0, 255)));
      set_eng(1, (t % 5) != 2, t[1], 16'($urandom_range(0, 255)));
      step();
    end

    // random traffic with changing latency
    for (int t = 0; t < 300; t++) begin
      if (t % 50 == 0) lat = $urandom_range(1, 8);
      set_eng(0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 16'($urandom_range(0, 255)));
      set_eng(1, $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0, 16'($urandom_range(0, 255)));
      step();
    end
    rq_req = 2'b00;
    for (int t = 0; t < 12; t++) step();

    // reset with three reads in flight; their later returns are unexpected
    lat = 8;
    for (int t = 0; t < 3; t++) begin
      set_eng(0, 1'b1, 1'b0, 16'(t + 200));
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_eng(0, 1'b0, 1'b0, 16'h0);
    for (int t = 0; t < 12; t++) step();
    check_val("err_after_flush", 64'(err_rd_unexp), 64'(1'b1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
